// File: rtl/halfband_decim_if.sv
// Handshake and coefficient-load bundle for halfband_decim.
// The slave modport is the filter's view, the master modport is the driver's view.
interface halfband_decim_if #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int NTAPS = 11,
  parameter int OW    = 16
);
  localparam int CHW = $clog2(NCH);
  localparam int K   = (NTAPS + 1) / 4;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic [CHW-1:0]        in_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [OW-1:0]  out_data;
  logic [CHW-1:0]        out_ch;
  logic                  coef_we;
  logic [KW-1:0]         coef_addr;
  logic signed [CW-1:0]  coef_data;
  logic                  sat_flag;

  modport master (
    output in_valid, in_data, in_ch, out_ready, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, out_ch, sat_flag
  );

  modport slave (
    input  in_valid, in_data, in_ch, out_ready, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, out_ch, sat_flag
  );
endinterface

// File: rtl/halfband_decim.sv
// Time-multiplexed halfband decimate-by-2 FIR for NCH interleaved channels.
// One pre-adder/multiplier/accumulator walks the K symmetric tap pairs, then adds the fixed 0.5 centre tap.
module halfband_decim #(
  parameter int NCH   = 4,
  parameter int DW    = 16,
  parameter int CW    = 18,
  parameter int NTAPS = 11,
  parameter int OW    = 16
) (
  input logic             clk,
  input logic             rst,
  halfband_decim_if.slave bus
);
  localparam int CHW = $clog2(NCH);
  localparam int K   = (NTAPS + 1) / 4;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int M   = (NTAPS - 1) / 2;
  localparam int AW  = DW + CW + 2 + $clog2(K + 1);

  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  logic [1:0]            state;
  logic [KW-1:0]         j;
  logic [CHW-1:0]        ch_r;
  logic signed [AW-1:0]  acc;
  logic signed [DW-1:0]  hist [NCH][NTAPS];
  logic [NCH-1:0]        phase;
  logic signed [CW-1:0]  coef [K];
  logic                  out_valid_r;
  logic signed [OW-1:0]  out_data_r;
  logic [CHW-1:0]        out_ch_r;
  logic                  sat_flag_r;

  logic                  accept;
  logic                  ch_ok;
  logic                  addr_ok;

  logic signed [DW-1:0]  xa, xb, xc;
  logic signed [CW-1:0]  cf;
  logic signed [DW:0]    pre;
  logic signed [DW+CW:0] prod;
  logic signed [AW-1:0]  acc_mac, fin_sum, res;
  logic signed [OW-1:0]  sat_val;
  logic                  clip;

  // Range checks are only real logic when the index field can encode values past the end.
  if (NCH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (32'(bus.in_ch) < NCH);
  end

  if (K == (1 << KW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = (32'(bus.coef_addr) < K);
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_ch    = out_ch_r;
  assign bus.sat_flag  = sat_flag_r;

  always_comb begin
    xa = '0;
    xb = '0;
    cf = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (j == KW'(i)) begin
        xa = hist[ch_r][2*i];
        xb = hist[ch_r][NTAPS-1-2*i];
        cf = coef[i];
      end
    end
    xc      = hist[ch_r][M];
    pre     = {xa[DW-1], xa} + {xb[DW-1], xb};
    prod    = (DW+CW+1)'(pre) * (DW+CW+1)'(cf);
    acc_mac = acc + {{(AW-DW-CW-1){prod[DW+CW]}}, prod};
    // Centre tap is 0.5 in Q1.(CW-1), i.e. x[M] scaled by 2^(CW-2).
    fin_sum = acc + {{(AW-DW-CW+2){xc[DW-1]}}, xc, {(CW-2){1'b0}}};
    res     = fin_sum >>> (CW-1);
    clip    = 1'b0;
    sat_val = res[OW-1:0];
    if (res > OMAX) begin
      sat_val = OMAX[OW-1:0];
      clip    = 1'b1;
    end else if (res < OMIN) begin
      sat_val = OMIN[OW-1:0];
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      j           <= '0;
      ch_r        <= '0;
      acc         <= '0;
      phase       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      sat_flag_r  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++)
        for (int unsigned t = 0; t < NTAPS; t++)
          hist[c][t] <= '0;
      for (int unsigned i = 0; i < K; i++)
        coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we && addr_ok)
            coef[bus.coef_addr] <= bus.coef_data;
          if (accept && ch_ok) begin
            for (int unsigned t = NTAPS-1; t > 0; t--)
              hist[bus.in_ch][t] <= hist[bus.in_ch][t-1];
            hist[bus.in_ch][0] <= bus.in_data;
            phase[bus.in_ch]   <= ~phase[bus.in_ch];
            if (phase[bus.in_ch]) begin
              ch_r  <= bus.in_ch;
              j     <= '0;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
        MAC: begin
          acc <= acc_mac;
          if (j == KW'(K-1))
            state <= FIN;
          else
            j <= j + KW'(1);
        end
        FIN: begin
          acc         <= fin_sum;
          out_data_r  <= sat_val;
          out_ch_r    <= ch_r;
          out_valid_r <= 1'b1;
          if (clip)
            sat_flag_r <= 1'b1;
          state <= OUT;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
